// File: rtl/msk_g16_inv_dom.sv
// msk_g16_inv_dom: d-share DOM-masked GF(16) inverter computing x^14 with two DOM multiplications
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in0..in3 carry bit k of every share (bit i = share i)
//   rnd/rnd_req         fresh randomness, sampled while rnd_req is high
//   out_valid/out_ready output handshake; out0..out3 carry the sharing of x^-1
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif
module msk_g16_inv_dom #(
   parameter int d = `DEFAULTSHARES,
   localparam int n_rnd = 4*d*(d-1)/2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [d-1:0]     in0,
   input  logic [d-1:0]     in1,
   input  logic [d-1:0]     in2,
   input  logic [d-1:0]     in3,
   input  logic [n_rnd-1:0] rnd,
   output logic             rnd_req,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [d-1:0]     out0,
   output logic [d-1:0]     out1,
   output logic [d-1:0]     out2,
   output logic [d-1:0]     out3
);
   typedef enum logic [1:0] {IDLE, MUL1, MUL2, OUT} state_t;
   state_t state_q;
   logic in_ready_q, out_valid_q, rnd_req_q;
   logic [3:0] x_q [d];
   logic [3:0] x2_q [d];
   logic [3:0] p1_q [d][d];
   logic [3:0] p2_q [d][d];
   logic [3:0] x_d [d];
   logic [3:0] x2_d [d];
   logic [3:0] x3 [d];
   logic [3:0] x12 [d];
   logic [3:0] y [d];
   logic [3:0] p1_d [d][d];
   logic [3:0] p2_d [d][d];
   // polynomial basis, reduction polynomial x^4 + x + 1
   function automatic logic [3:0] g16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p, s;
      p = '0;
      s = a;
      for (int k = 0; k < 4; k++) begin
         p = b[k] ? p ^ s : p;
         s = {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000);
      end
      return p;
   endfunction
   function automatic logic [3:0] g16_sq(input logic [3:0] a);
      return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
   endfunction
   // r_ij = r_ji taken from the packed upper triangle, r_ii = 0
   function automatic logic [3:0] rnd_pair(input logic [n_rnd-1:0] r, input int i, input int j);
      int a, b, k;
      a = i < j ? i : j;
      b = i < j ? j : i;
      k = (i == j) ? 0 : a*d - a*(a+1)/2 + b - a - 1;
      return (i == j) ? 4'b0000 : r[4*k +: 4];
   endfunction
   always_comb begin
      out0 = '0;
      out1 = '0;
      out2 = '0;
      out3 = '0;
      for (int i = 0; i < d; i++) begin
         x_d[i]  = {in3[i], in2[i], in1[i], in0[i]};
         x2_d[i] = g16_sq(x_d[i]);
         x3[i]   = '0;
         y[i]    = '0;
         for (int j = 0; j < d; j++) begin
            x3[i] = x3[i] ^ p1_q[i][j];
            y[i]  = y[i] ^ p2_q[i][j];
         end
         x12[i]  = g16_sq(g16_sq(x3[i]));
         out0[i] = y[i][0];
         out1[i] = y[i][1];
         out2[i] = y[i][2];
         out3[i] = y[i][3];
      end
      for (int i = 0; i < d; i++)
         for (int j = 0; j < d; j++) begin
            p1_d[i][j] = g16_mul(x_q[i], x2_q[j]) ^ rnd_pair(rnd, i, j);
            p2_d[i][j] = g16_mul(x12[i], x2_q[j]) ^ rnd_pair(rnd, i, j);
         end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rnd_req_q   <= 1'b0;
         for (int i = 0; i < d; i++) begin
            x_q[i]  <= '0;
            x2_q[i] <= '0;
            for (int j = 0; j < d; j++) begin
               p1_q[i][j] <= '0;
               p2_q[i][j] <= '0;
            end
         end
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               state_q    <= MUL1;
               in_ready_q <= 1'b0;
               rnd_req_q  <= 1'b1;
               x_q        <= x_d;
               x2_q       <= x2_d;
            end
            MUL1: begin
               state_q <= MUL2;
               p1_q    <= p1_d;
            end
            MUL2: begin
               state_q     <= OUT;
               rnd_req_q   <= 1'b0;
               out_valid_q <= 1'b1;
               p2_q        <= p2_d;
            end
            default: if (out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign rnd_req   = rnd_req_q;
endmodule

// File: tb/tb_msk_g16_inv_dom.sv
// tb_msk_g16_inv_dom: scoreboard bench for the masked GF(16) inverter at d=2 and d=3
module tb_msk_g16_inv_dom;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst3_n = 1'b0;
   always #5 clk = ~clk;
   logic iv2, ir2, ov2, or2, rr2;
   logic [1:0] i20, i21, i22, i23, o20, o21, o22, o23;
   logic [3:0] rnd2;
   logic iv3, ir3, ov3, or3, rr3;
   logic [2:0] i30, i31, i32, i33, o30, o31, o32, o33;
   logic [11:0] rnd3;
   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] q2 [$];
   logic [3:0] q3 [$];
   logic done3 = 1'b0;
   logic seen2 = 1'b0;
   logic seen3 = 1'b0;
   logic [3:0] y2, y3;
   logic [7:0] snap;
   // hand-computed inverses in GF(16), polynomial basis mod x^4+x+1
   logic [3:0] inv_t [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                              4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};
   msk_g16_inv_dom #(.d(2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .in0(i20), .in1(i21), .in2(i22), .in3(i23), .rnd(rnd2), .rnd_req(rr2),
      .out_valid(ov2), .out_ready(or2), .out0(o20), .out1(o21), .out2(o22), .out3(o23)
   );
   msk_g16_inv_dom #(.d(3)) u3 (
      .clk(clk), .rst_n(rst3_n), .in_valid(iv3), .in_ready(ir3),
      .in0(i30), .in1(i31), .in2(i32), .in3(i33), .rnd(rnd3), .rnd_req(rr3),
      .out_valid(ov3), .out_ready(or3), .out0(o30), .out1(o31), .out2(o32), .out3(o33)
   );
   always @(negedge clk) begin
      rnd2 = 4'($urandom);
      rnd3 = 12'($urandom);
   end
   always_comb begin
      y2 = '0;
      y3 = '0;
      for (int i = 0; i < 2; i++) y2 = y2 ^ {o23[i], o22[i], o21[i], o20[i]};
      for (int i = 0; i < 3; i++) y3 = y3 ^ {o33[i], o32[i], o31[i], o30[i]};
   end
   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired", nm);
   endtask
   // monitors: each result is compared once, on the first cycle out_valid is seen
   always @(negedge clk) begin
      if (!rst_n) seen2 = 1'b0;
      else if (ov2 && !seen2) begin
         seen2 = 1'b1;
         if (q2.size() == 0) fail_now("inv2 unexpected output");
         else chk("inv2", y2, q2.pop_front());
      end else if (!ov2) seen2 = 1'b0;
   end
   always @(negedge clk) begin
      if (!rst3_n) seen3 = 1'b0;
      else if (ov3 && !seen3) begin
         seen3 = 1'b1;
         if (q3.size() == 0) fail_now("inv3 unexpected output");
         else chk("inv3", y3, q3.pop_front());
      end else if (!ov3) seen3 = 1'b0;
   end
   task automatic issue2(input logic [3:0] x, input bit exp);
      logic [3:0] s0;
      int t;
      s0 = 4'($urandom);
      t = 0;
      while (!ir2 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!ir2) begin
         fail_now("issue2 in_ready");
         return;
      end
      {i23[0], i22[0], i21[0], i20[0]} = s0;
      {i23[1], i22[1], i21[1], i20[1]} = s0 ^ x;
      iv2 = 1'b1;
      if (exp) q2.push_back(inv_t[x]);
      @(posedge clk);
      #1 iv2 = 1'b0;
   endtask
   task automatic issue3(input logic [3:0] x);
      logic [3:0] s0, s1;
      int t;
      s0 = 4'($urandom);
      s1 = 4'($urandom);
      t = 0;
      while (!ir3 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!ir3) begin
         fail_now("issue3 in_ready");
         return;
      end
      {i33[0], i32[0], i31[0], i30[0]} = s0;
      {i33[1], i32[1], i31[1], i30[1]} = s1;
      {i33[2], i32[2], i31[2], i30[2]} = s0 ^ s1 ^ x;
      iv3 = 1'b1;
      q3.push_back(inv_t[x]);
      @(posedge clk);
      #1 iv3 = 1'b0;
   endtask
   task automatic drain2();
      int t;
      t = 0;
      while ((q2.size() != 0 || !ir2) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (q2.size() != 0) fail_now("drain2");
   endtask
   initial begin
      iv3 = 1'b0;
      or3 = 1'b1;
      {i30, i31, i32, i33} = '0;
      repeat (3) @(negedge clk);
      rst3_n = 1'b1;
      @(negedge clk);
      for (int v = 0; v < 16; v++) issue3(4'(v));
      for (int t = 0; t < 50 && q3.size() != 0; t++) @(negedge clk);
      if (q3.size() != 0) fail_now("drain3");
      done3 = 1'b1;
   end
   initial begin
      iv2 = 1'b0;
      or2 = 1'b1;
      {i20, i21, i22, i23} = '0;
      repeat (2) @(negedge clk);
      chk("rst in_ready", 4'(ir2), 4'd1);
      chk("rst out_valid", 4'(ov2), 4'd0);
      chk("rst rnd_req", 4'(rr2), 4'd0);
      chk("rst outs", 4'({o20, o21, o22, o23} != 0), 4'd0);
      rst_n = 1'b1;
      @(negedge clk);
      issue2(4'h1, 1'b1);
      @(negedge clk);
      chk("lat c0 rnd_req", 4'(rr2), 4'd1);
      chk("lat c0 out_valid", 4'(ov2), 4'd0);
      @(negedge clk);
      chk("lat c1 rnd_req", 4'(rr2), 4'd1);
      chk("lat c1 out_valid", 4'(ov2), 4'd0);
      @(negedge clk);
      chk("lat c2 rnd_req", 4'(rr2), 4'd0);
      chk("lat c2 out_valid", 4'(ov2), 4'd1);
      @(negedge clk);
      chk("lat c3 out_valid", 4'(ov2), 4'd0);
      chk("lat c3 in_ready", 4'(ir2), 4'd1);
      issue2(4'h0, 1'b1);
      for (int v = 0; v < 16; v++) issue2(4'(v), 1'b1);
      drain2();
      or2 = 1'b0;
      issue2(4'h7, 1'b1);
      for (int t = 0; t < 10 && !ov2; t++) @(negedge clk);
      chk("bp out_valid", 4'(ov2), 4'd1);
      snap = {o23, o22, o21, o20};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp hold outs", 4'({o23, o22, o21, o20} != snap), 4'd0);
         chk("bp in_ready", 4'(ir2), 4'd0);
      end
      or2 = 1'b1;
      @(negedge clk);
      chk("bp release in_ready", 4'(ir2), 4'd1);
      chk("bp release out_valid", 4'(ov2), 4'd0);
      issue2(4'h2, 1'b1);
      @(negedge clk);
      {i23[0], i22[0], i21[0], i20[0]} = 4'h3;
      {i23[1], i22[1], i21[1], i20[1]} = 4'h6;
      iv2 = 1'b1;
      chk("busy mul1 in_ready", 4'(ir2), 4'd0);
      @(negedge clk);
      chk("busy mul2 in_ready", 4'(ir2), 4'd0);
      @(negedge clk);
      iv2 = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy no extra output", 4'(ov2), 4'd0);
      chk("busy idle", 4'(ir2), 4'd1);
      issue2(4'h3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("mid mul2 rnd_req", 4'(rr2), 4'd1);
      rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", 4'(ov2), 4'd0);
      chk("mid rst rnd_req", 4'(rr2), 4'd0);
      chk("mid rst in_ready", 4'(ir2), 4'd1);
      chk("mid rst outs", 4'({o20, o21, o22, o23} != 0), 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue2(4'hB, 1'b1);
      drain2();
      for (int t = 0; t < 2000 && !done3; t++) @(negedge clk);
      if (!done3) fail_now("d3 sequence");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/msk_g16_inv_dom.md
Name: msk_g16_inv_dom

Overview:
- Masked GF(16) inverter; the inverse-direction companion to the DOM GF(16) multiplier.
- Computes x^-1 = x^14 on a d-share Boolean sharing, so 0 maps to 0.
- Uses two sequential DOM multiplications and sharewise (linear) squarings, driven by a small FSM with valid/ready handshakes.
- Sits in the masked tower-field S-box path, between the GF(256)→GF(16) reduction and the output GF(16) multiplications.

Parameters:
- d, `DEFAULTSHARES (2), number of shares, d ≥ 2.
- n_rnd (localparam), 4*d*(d-1)/2, fresh random bits per DOM multiplication.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input sharing valid.
- in_ready, output, 1: block accepts input.
- in0..in3, input, d each: bit k of every share of x; bit i of ink is share i.
- rnd, input, n_rnd: fresh randomness, consumed whenever rnd_req=1.
- rnd_req, output, 1: rnd is sampled this cycle and must be fresh and uniform.
- out_valid, output, 1: result sharing valid.
- out_ready, input, 1: consumer accepts result.
- out0..out3, output, d each: sharing of x^-1, same bit/share layout as in0..in3.

Behaviour:
- Field representation: identical to the codebase G16_mul basis.
- Squaring: linear, applied sharewise with no randomness (G16 squaring in the same basis).
- FSM states: IDLE, MUL1, MUL2, OUT.
- Reset (async assert, sync release) sets:
  - state = IDLE;
  - x, x2 and both DOM partial-product register banks = 0;
  - in_ready = 1, out_valid = 0, rnd_req = 0, out0..out3 = 0.
- in_ready = (state == IDLE).
- out_valid = (state == OUT).
- rnd_req = (state == MUL1 || state == MUL2).
- IDLE:
  - On in_valid && in_ready at the edge: capture x shares and x2 = sq(x) shares into registers; go to MUL1.
  - Otherwise stay in IDLE.
- MUL1:
  - DOM product x3 = x * x2.
  - For every share pair (i,j): G16_mul(x_i, x2_j) XOR r_ij, where r_ij = r_ji, r_ii = 0, and r is drawn from rnd using the standard triangular offset order.
  - d*d 4-bit results are registered at the edge; go to MUL2.
- MUL2:
  - x3_i = XOR over j of the MUL1 registers for row i.
  - x12_i = sq(sq(x3_i)), sharewise.
  - DOM product x14 = x12 * x2, with fresh rnd in the same layout.
  - Results registered at the edge; go to OUT.
- OUT:
  - out_i = XOR over j of the MUL2 registers for row i.
  - All partial-product registers hold (clock-enabled), so outputs stay stable under back-pressure.
  - On out_ready, go to IDLE at the edge.
- Latency: accept edge E0 → out_valid high after E2 (3 cycles after accept). Minimum initiation interval is 4 cycles.
- Register enables:
  - MUL1 bank loads only in MUL1.
  - MUL2 bank loads only in MUL2.
  - x/x2 registers load only on the input handshake and are held through MUL2.
- Concurrent events:
  - in_valid outside IDLE is ignored; in_ready = 0.
  - out_ready outside OUT is ignored.
- Reset mid-operation (any state) aborts the operation and clears all registers; no partial output appears.
- No combinational path from in* to out*. Each DOM register bank is the only point where cross-share products meet, so output shares are glitch-safe.
- Security property: (d-1)-probing secure when rnd_req cycles receive fresh uniform randomness (2*n_rnd bits per inversion).

Test Plan:
- d=2: input sharing of the field identity with a random mask; out_ready=1 → out_valid high exactly 3 cycles after accept; recombined output = identity; rnd_req high for exactly 2 cycles.
- d=2: zero input (shares a, a for random a) → recombined output = 0.
- d=2 and d=3: exhaustive over all 16 values, random masks and rnd → recombine(out) G16_mul recombine(in) = identity for every x≠0; output matches a reference x^14 model.
- Back-pressure: hold out_ready=0 for 5 cycles in OUT while rnd toggles → out0..out3 stable, in_ready=0; assert out_ready → IDLE next cycle, in_ready=1.
- Busy rejection: pulse in_valid with a new value during MUL1/MUL2 → ignored; the result is for the first input only.
- Reset: drop rst_n during MUL2 → immediately state IDLE, out_valid=0, rnd_req=0, outputs 0. After release, a new accept completes normally.
